pc_unit: RTL and testbench

Parametrised program-counter unit for the team's single-issue RISC-V core. It generalises the fetch PC register with configurable width, reset and trap vectors, and alignment. It adds JALR targeting, misaligned-target detection, a trap/MRET redirect path with EPC/cause capture, and a halt/resume state machine for debug. It sits between decode/branch-compare and instruction fetch, and drives the fetch address and the AUIPC/link value.

---
 rtl/core_pkg.sv | 20 ++
 rtl/pc_target_calc.sv | 27 ++
 rtl/pc_unit.sv | 151 +++++++++++++++
 tb/tb_pc_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the single-issue core: PC controller states,
// default vectors, data width and trap cause encodings.
package core_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } pc_state_e;

  localparam int XLEN_DEFAULT    = 32;
  localparam int CAUSE_W_DEFAULT = 4;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

  localparam logic [3:0] CAUSE_MISALIGNED_FETCH = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
  localparam logic [3:0] CAUSE_ECALL            = 4'd11;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates and target alignment check.
// Kept standalone so the branch predictor can share the same arithmetic.
module pc_target_calc #(
  parameter int XLEN   = 32,
  parameter int IALIGN = 4
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            jalr_i,
  output logic [XLEN-1:0] seq_o,
  output logic [XLEN-1:0] rel_o,
  output logic [XLEN-1:0] abs_o,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  always_comb begin
    seq_o    = pc_i + XLEN'(4);
    rel_o    = pc_i + imm_i;
    abs_o    = (rs1_i + imm_i) & ~(XLEN'(1));
    target_o = jalr_i ? abs_o : rel_o;
    // bit0 is always clear for legal targets, so only bit1 matters at 4-byte alignment
    misaligned_o = (IALIGN == 4) ? target_o[1] : 1'b0;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with branch/JALR redirect, trap/MRET handling
// and a debug halt/resume controller.
module pc_unit
  import core_pkg::*;
#(
  parameter int                   XLEN           = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]      RESET_VECTOR   = XLEN'(RESET_VECTOR_DEFAULT),
  parameter logic [XLEN-1:0]      TRAP_VECTOR    = XLEN'(TRAP_VECTOR_DEFAULT),
  parameter int                   IALIGN         = 4,
  parameter int                   CAUSE_W        = CAUSE_W_DEFAULT,
  parameter logic [CAUSE_W-1:0]   MISALIGN_CAUSE = CAUSE_W'(CAUSE_MISALIGNED_FETCH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic               in_en,
  input  logic               branch_decision,
  input  logic               jalr,
  input  logic [XLEN-1:0]    rs1_value,
  input  logic [XLEN-1:0]    generated_immediate,
  input  logic               auipc_in,
  input  logic               trap_req,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic               mret,
  input  logic               halt_req,
  input  logic               resume,
  output logic [XLEN-1:0]    pc_out,
  output logic [XLEN-1:0]    pc_add_out,
  output logic [XLEN-1:0]    epc_out,
  output logic [CAUSE_W-1:0] cause_out,
  output logic               flush,
  output logic               halted,
  output logic               misaligned
);

  pc_state_e          state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               flush_q, flush_d;
  logic               mis_q, mis_d;

  logic               commit;
  logic               redirect;
  logic [XLEN-1:0]    seq_w, rel_w, abs_w, target_w;
  logic               target_mis_w;
  logic               unused_abs;

  pc_target_calc #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_target_calc (
    .pc_i         (pc_q),
    .rs1_i        (rs1_value),
    .imm_i        (generated_immediate),
    .jalr_i       (jalr),
    .seq_o        (seq_w),
    .rel_o        (rel_w),
    .abs_o        (abs_w),
    .target_o     (target_w),
    .misaligned_o (target_mis_w)
  );

  // abs is already folded into target; kept on the port for the predictor
  assign unused_abs = ^abs_w;

  // ---------------- halt/resume FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = HALT;
      HALT:    if (resume)   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    halted = (state_q == HALT);
    commit = en && in_en && (state_q == RUN);
  end

  // ---------------- PC / trap datapath ----------------
  assign redirect = branch_decision | jalr;

  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    flush_d = 1'b0;
    mis_d   = 1'b0;
    if (commit) begin
      if (trap_req) begin
        pc_d    = TRAP_VECTOR;
        epc_d   = pc_q;
        cause_d = trap_cause;
        flush_d = 1'b1;
      end else if (redirect && target_mis_w) begin
        pc_d    = TRAP_VECTOR;
        epc_d   = pc_q;
        cause_d = MISALIGN_CAUSE;
        flush_d = 1'b1;
        mis_d   = 1'b1;
      end else if (mret) begin
        pc_d    = epc_q;
        flush_d = 1'b1;
      end else if (redirect) begin
        pc_d    = target_w;
        flush_d = 1'b1;
      end else begin
        pc_d    = seq_w;
      end
    end
  end

  // Pulses are cleared every cycle; architectural registers hold under stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      cause_q <= '0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      flush_q <= flush_d;
      mis_q   <= mis_d;
      if (en) begin
        pc_q    <= pc_d;
        epc_q   <= epc_d;
        cause_q <= cause_d;
      end
    end
  end

  always_comb begin
    pc_out     = pc_q;
    pc_add_out = auipc_in ? rel_w : seq_w;
    epc_out    = epc_q;
    cause_out  = cause_q;
    flush      = flush_q;
    misaligned = mis_q;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized checks of pc_unit against a spec-level reference model.
module tb_pc_unit;
  import core_pkg::*;

  logic        clock = 1'b0;
  logic        reset, en, in_en, branch_decision, jalr, auipc_in;
  logic        trap_req, mret, halt_req, resume;
  logic [31:0] rs1_value, generated_immediate;
  logic [3:0]  trap_cause;
  logic [31:0] pc_out, pc_add_out, epc_out;
  logic [3:0]  cause_out;
  logic        flush, halted, misaligned;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pc, m_epc;
  logic [3:0]  m_cause;
  logic        m_flush, m_mis, m_halt;

  pc_unit dut (
    .clock(clock), .reset(reset), .en(en), .in_en(in_en),
    .branch_decision(branch_decision), .jalr(jalr), .rs1_value(rs1_value),
    .generated_immediate(generated_immediate), .auipc_in(auipc_in),
    .trap_req(trap_req), .trap_cause(trap_cause), .mret(mret),
    .halt_req(halt_req), .resume(resume), .pc_out(pc_out),
    .pc_add_out(pc_add_out), .epc_out(epc_out), .cause_out(cause_out),
    .flush(flush), .halted(halted), .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  task automatic set_idle();
    reset = 0; en = 1; in_en = 0; branch_decision = 0; jalr = 0; auipc_in = 0;
    trap_req = 0; trap_cause = 0; mret = 0; halt_req = 0; resume = 0;
    rs1_value = 0; generated_immediate = 0;
  endtask

  // Advance one clock; the model applies the architectural rules to the current inputs.
  task automatic tick();
    logic [31:0] n_pc, n_epc, tgt;
    logic [3:0]  n_cause;
    logic        n_f, n_m, n_h;
    n_pc = m_pc; n_epc = m_epc; n_cause = m_cause; n_h = m_halt; n_f = 0; n_m = 0;
    if (reset) begin
      n_pc = 32'h0; n_epc = 0; n_cause = 0; n_h = 0;
    end else if (en) begin
      if (!m_halt) begin
        if (in_en) begin
          tgt = jalr ? ((rs1_value + generated_immediate) & 32'hFFFF_FFFE)
                     : (m_pc + generated_immediate);
          if (trap_req) begin
            n_pc = 32'h100; n_epc = m_pc; n_cause = trap_cause; n_f = 1;
          end else if ((branch_decision || jalr) && (tgt % 4 != 0)) begin
            n_pc = 32'h100; n_epc = m_pc; n_cause = 4'd0; n_f = 1; n_m = 1;
          end else if (mret) begin
            n_pc = m_epc; n_f = 1;
          end else if (branch_decision || jalr) begin
            n_pc = tgt; n_f = 1;
          end else begin
            n_pc = m_pc + 4;
          end
        end
        if (halt_req) n_h = 1;
      end else if (resume) begin
        n_h = 0;
      end
    end
    @(posedge clock);
    #1;
    m_pc = n_pc; m_epc = n_epc; m_cause = n_cause; m_flush = n_f; m_mis = n_m; m_halt = n_h;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    set_idle();
    in_en = 1; jalr = 1; rs1_value = addr;
    tick();
    set_idle();
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1;
    tick();
    set_idle();
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1; en = 0; branch_decision = 1; in_en = 1;
    tick();
    set_idle();
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp %h", pc_out, 32'h0); end
    tests++; if (epc_out !== 32'h0) begin fails++; $display("FAIL reset_epc got %h exp 0", epc_out); end
    tests++; if (cause_out !== 4'h0) begin fails++; $display("FAIL reset_cause got %h exp 0", cause_out); end
    tests++; if ({flush, misaligned, halted} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {flush, misaligned, halted}); end
  endtask

  task automatic test_sequential();
    do_reset();
    in_en = 1;
    #1;
    tests++; if (pc_add_out !== 32'h4) begin fails++; $display("FAIL seq_add0 got %h exp 4", pc_add_out); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      tests++; if (pc_out !== 32'(i * 4)) begin fails++; $display("FAIL seq_pc%0d got %h exp %h", i, pc_out, 32'(i * 4)); end
      tests++; if (pc_add_out !== 32'(i * 4 + 4)) begin fails++; $display("FAIL seq_add%0d got %h exp %h", i, pc_add_out, 32'(i * 4 + 4)); end
      tests++; if (flush !== 1'b0) begin fails++; $display("FAIL seq_flush%0d got %b exp 0", i, flush); end
    end
    set_idle();
  endtask

  task automatic test_branch();
    jump_to(32'h20);
    tests++; if (pc_out !== 32'h20) begin fails++; $display("FAIL br_setup got %h exp 20", pc_out); end
    in_en = 1; branch_decision = 1; generated_immediate = 32'hFFFF_FFF0;
    #1;
    tests++; if (pc_add_out !== 32'h24) begin fails++; $display("FAIL br_link got %h exp 24", pc_add_out); end
    tick();
    tests++; if (pc_out !== 32'h10) begin fails++; $display("FAIL br_pc got %h exp 10", pc_out); end
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL br_flush got %b exp 1", flush); end
    set_idle(); in_en = 1;
    tick();
    tests++; if (flush !== 1'b0 || pc_out !== 32'h14) begin fails++; $display("FAIL br_after got flush=%b pc=%h exp flush=0 pc=14", flush, pc_out); end
    jump_to(32'h20);
    in_en = 1; branch_decision = 1; auipc_in = 1; generated_immediate = 32'h100;
    #1;
    tests++; if (pc_add_out !== 32'h120) begin fails++; $display("FAIL auipc got %h exp 120", pc_add_out); end
    tick();
    tests++; if (pc_out !== 32'h120) begin fails++; $display("FAIL br2_pc got %h exp 120", pc_out); end
    set_idle();
  endtask

  task automatic test_misaligned();
    jump_to(32'h40);
    in_en = 1; jalr = 1; rs1_value = 32'h1003; generated_immediate = 0;
    tick();
    tests++; if (pc_out !== 32'h100) begin fails++; $display("FAIL mis_pc got %h exp 100", pc_out); end
    tests++; if (epc_out !== 32'h40) begin fails++; $display("FAIL mis_epc got %h exp 40", epc_out); end
    tests++; if (cause_out !== 4'd0) begin fails++; $display("FAIL mis_cause got %h exp 0", cause_out); end
    tests++; if ({misaligned, flush} !== 2'b11) begin fails++; $display("FAIL mis_pulse got %b exp 11", {misaligned, flush}); end
    set_idle(); in_en = 1; mret = 1;
    tick();
    tests++; if (pc_out !== 32'h40) begin fails++; $display("FAIL mret_pc got %h exp 40", pc_out); end
    tests++; if ({misaligned, flush} !== 2'b01) begin fails++; $display("FAIL mret_pulse got %b exp 01", {misaligned, flush}); end
    set_idle();
  endtask

  task automatic test_trap_priority();
    jump_to(32'h80);
    in_en = 1; trap_req = 1; trap_cause = CAUSE_ILLEGAL; branch_decision = 1; generated_immediate = 32'h40;
    tick();
    tests++; if (pc_out !== 32'h100) begin fails++; $display("FAIL trap_pc got %h exp 100", pc_out); end
    tests++; if (epc_out !== 32'h80) begin fails++; $display("FAIL trap_epc got %h exp 80", epc_out); end
    tests++; if (cause_out !== 4'd2) begin fails++; $display("FAIL trap_cause got %h exp 2", cause_out); end
    tests++; if (misaligned !== 1'b0) begin fails++; $display("FAIL trap_mis got %b exp 0", misaligned); end
    set_idle();
  endtask

  task automatic test_halt();
    do_reset();
    in_en = 1;
    tick(); tick();
    tests++; if (pc_out !== 32'h8) begin fails++; $display("FAIL halt_setup got %h exp 8", pc_out); end
    halt_req = 1;
    tick();
    halt_req = 0;
    tests++; if (pc_out !== 32'hC || halted !== 1'b1) begin fails++; $display("FAIL halt_entry got pc=%h halted=%b exp pc=c halted=1", pc_out, halted); end
    for (int i = 0; i < 5; i++) begin
      branch_decision = i[0]; trap_req = i[1]; generated_immediate = 32'h40;
      tick();
      tests++; if (pc_out !== 32'hC || halted !== 1'b1 || flush !== 1'b0) begin fails++; $display("FAIL halt_hold%0d got pc=%h halted=%b flush=%b exp pc=c halted=1 flush=0", i, pc_out, halted, flush); end
    end
    set_idle(); in_en = 1; resume = 1; halt_req = 1;
    tick();
    tests++; if (pc_out !== 32'hC || halted !== 1'b0) begin fails++; $display("FAIL resume got pc=%h halted=%b exp pc=c halted=0", pc_out, halted); end
    halt_req = 0; resume = 1;
    tick();
    tests++; if (pc_out !== 32'h10 || halted !== 1'b0) begin fails++; $display("FAIL resume_run got pc=%h halted=%b exp pc=10 halted=0", pc_out, halted); end
    set_idle();
  endtask

  task automatic test_wrap_stall();
    jump_to(32'hFFFF_FFFC);
    in_en = 1;
    #1;
    tests++; if (pc_add_out !== 32'h0) begin fails++; $display("FAIL wrap_add got %h exp 0", pc_add_out); end
    tick();
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL wrap_pc got %h exp 0", pc_out); end
    en = 0; branch_decision = 1; generated_immediate = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (pc_out !== 32'h0 || flush !== 1'b0) begin fails++; $display("FAIL stall%0d got pc=%h flush=%b exp pc=0 flush=0", i, pc_out, flush); end
    end
    en = 1;
    tick();
    tests++; if (pc_out !== 32'h200 || flush !== 1'b1) begin fails++; $display("FAIL stall_release got pc=%h flush=%b exp pc=200 flush=1", pc_out, flush); end
    set_idle(); halt_req = 1;
    tick();
    set_idle(); reset = 1;
    tick();
    set_idle();
    tests++; if (pc_out !== 32'h0 || halted !== 1'b0) begin fails++; $display("FAIL halt_reset got pc=%h halted=%b exp pc=0 halted=0", pc_out, halted); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset           = ($urandom_range(0, 60) == 0);
      en              = ($urandom_range(0, 7) != 0);
      in_en           = ($urandom_range(0, 3) != 0);
      branch_decision = ($urandom_range(0, 3) == 0);
      jalr            = ($urandom_range(0, 5) == 0);
      auipc_in        = $urandom_range(0, 1);
      trap_req        = ($urandom_range(0, 9) == 0);
      trap_cause      = $urandom_range(0, 15);
      mret            = ($urandom_range(0, 9) == 0);
      halt_req        = ($urandom_range(0, 15) == 0);
      resume          = ($urandom_range(0, 3) == 0);
      rs1_value       = $urandom;
      generated_immediate = $urandom & 32'hFFFF_FFFE;
      #1;
      tests++;
      if (pc_add_out !== (auipc_in ? m_pc + generated_immediate : m_pc + 4)) begin
        fails++; $display("FAIL rnd_add[%0d] got %h exp %h", i, pc_add_out, auipc_in ? m_pc + generated_immediate : m_pc + 4);
      end
      tick();
      tests++;
      if ({pc_out, epc_out, cause_out, flush, misaligned, halted} !== {m_pc, m_epc, m_cause, m_flush, m_mis, m_halt}) begin
        fails++;
        $display("FAIL rnd_state[%0d] got pc=%h epc=%h cause=%h f=%b m=%b h=%b exp pc=%h epc=%h cause=%h f=%b m=%b h=%b",
                 i, pc_out, epc_out, cause_out, flush, misaligned, halted, m_pc, m_epc, m_cause, m_flush, m_mis, m_halt);
      end
    end
    set_idle();
  endtask

  initial begin
    m_pc = 0; m_epc = 0; m_cause = 0; m_flush = 0; m_mis = 0; m_halt = 0;
    set_idle();
    test_reset();
    test_sequential();
    test_branch();
    test_misaligned();
    test_trap_priority();
    test_halt();
    test_wrap_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
